uart_rx_cfg: RTL and testbench
==============================

# uart_rx_cfg

Parametrised UART receiver, successor to the fixed 8N1 `uart_rx`. Frame format is set at elaboration time: 5–9 data bits, none/odd/even parity, 1 or 2 stop bits. Adds an input synchroniser, start-glitch rejection, 3-sample majority voting, parity/framing/break/overrun reporting and a valid/ack output handshake. It sits between a console pin and the mux's per-channel byte path.

## Interface
- `CLK_PER_BIT`, 100: clock cycles per bit. Must be ≥ 8.
- `DATA_BITS`, 8: data bits per frame, range 5–9. Sent LSB first.
- `PARITY`, 0: parity mode. 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: number of stop bits, 1 or 2.

Ports:
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `rx` in 1: serial line. Asynchronous to `clk`; idles high.
- `data` out DATA_BITS: received word. Stable while `data_valid` is high.
- `data_valid` out 1: a word is held. Stays high until acknowledged.
- `data_ack` in 1: consumer accepts the word in any cycle where `data_valid && data_ack`.
- `parity_err` out 1: parity mismatch for the held word. Always 0 when PARITY = 0.
- `frame_err` out 1: a stop bit sampled low for the held word.
- `break_det` out 1: held word is a break (all data bits 0, parity bit 0 if present, first stop bit 0).
- `overrun` out 1: sticky. A frame completed while `data_valid` was high and was dropped.

## Operation
- `rx` passes through a 2-flop synchroniser. All references to the "line" below mean the synchronised signal `rxs`.
- Bit timing: bit k of the frame (start bit = 0) is centred at offset `M = k*CLK_PER_BIT + CLK_PER_BIT/2` (integer division) from the start edge E.
- Majority vote: the line is sampled at M−1, M and M+1. The bit value is the 2-of-3 majority, decided at M+1.
- Parity covers the data bits only.
- States:
  - **WAIT_IDLE**: wait for the line to be high, then go to IDLE. This is the reset state and the state after any error or break.
  - **IDLE**: a high→low transition on the line defines E and moves to START.
  - **START**: vote on the start bit. A result of 1 is a glitch: return to IDLE with no output. A result of 0 moves to DATA.
  - **DATA**: DATA_BITS votes, shifted in LSB first.
  - **PARITY**: one vote. This state is skipped when PARITY = 0.
  - **STOP**: STOP_BITS votes. After the last stop vote, the frame completes:
    - If every stop bit voted 1, go to IDLE.
    - Otherwise set `frame_err`. If the break condition holds, also set `break_det`. Go to WAIT_IDLE.
- Frame completion while `data_valid` = 0:
  - The next cycle loads `data`, `parity_err`, `frame_err` and `break_det`, and raises `data_valid`.
- Frame completion while `data_valid` = 1:
  - The new frame is discarded. The held word and its flags are unchanged.
  - `overrun` is set.
- Acknowledge:
  - `data_valid && data_ack`: `data_valid` drops next cycle.
  - Error flags and `overrun` clear in that same cycle.
  - `data_ack` while `data_valid` = 0 is ignored.
- Simultaneous events: a frame completing in the same cycle as an ack counts as not an overrun. The new word loads the next cycle and `data_valid` stays high.
- Reset:
  - All outputs go to 0, including `data`. State goes to WAIT_IDLE and the synchroniser flops go to 1.
  - A reset asserted mid-frame discards the frame.
  - After reset release, no start edge is accepted until the line has been seen high.

## Timing
- Latency from a pin edge to `rxs` is 2 cycles.
- `data_valid` rises at E + (1 + DATA_BITS + P + STOP_BITS − 1)·CLK_PER_BIT + CLK_PER_BIT/2 + 2, where P = (PARITY≠0).
  - Example, 8N1 with CLK_PER_BIT = 100: E + 952.
- Back-to-back frames: the next start edge is accepted from the cycle after the last stop vote. A 0% gap between frames is therefore supported.
- Tolerated baud mismatch is ±(CLK_PER_BIT/2 − 2)/(CLK_PER_BIT·frame_bits).
- No combinational path from `rx` or `data_ack` to any output.

## Test plan
- **Defaults (8N1), loopback through `uart_tx`, all 256 byte values, ack 1 cycle after `data_valid`.**
  - Every `data` equals the sent byte.
  - All error flags stay 0.
  - Each `data_valid` rises at E + 952.
- **DATA_BITS = 7, PARITY = 2, STOP_BITS = 2; send 0x55 with correct parity, then 0x55 with the parity bit inverted.**
  - First frame: `data` = 0x55, `parity_err` = 0.
  - Second frame: `data` = 0x55, `parity_err` = 1.
- **Defaults; 20-cycle low pulse on `rx` from idle, followed by a valid frame 0xA3.**
  - The pulse produces no `data_valid`.
  - The frame is received as 0xA3.
- **Defaults; hold `rx` low for 15 bit times, then high.**
  - One word: `data` = 0x00, `frame_err` = 1, `break_det` = 1.
  - No further word until a new valid frame is sent.
- **Defaults; send 0x11 then 0x22 back-to-back, no ack.**
  - `data` stays 0x11 and `overrun` = 1.
  - After ack, all outputs are 0 and 0x22 is not delivered.
  - Then send 0x33 with ack in its completion cycle: received normally, `overrun` = 0.
- **Defaults; assert `rst_n` low mid-frame during the data bits of 0xF0, release while `rx` is still in the frame.**
  - No `data_valid` for the interrupted frame.
  - The next full frame, 0x5A, is received correctly.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised UART receiver.
//
// Frame format is fixed at elaboration: DATA_BITS (5-9) data bits sent LSB
// first, optional odd/even parity, 1 or 2 stop bits. Each bit is decided by a
// 2-of-3 vote around its centre.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   rx          in   serial line, asynchronous to clk, idles high
//   data        out  received word, stable while data_valid is high
//   data_valid  out  a word is held until data_ack is seen
//   data_ack    in   consumer accepts the held word
//   parity_err  out  parity mismatch for the held word
//   frame_err   out  a stop bit sampled low for the held word
//   break_det   out  held word is a line break
//   overrun     out  sticky: a completed frame was dropped while a word was held
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_WAIT_IDLE | wait for a real (post-reset) high sample on the line
// S_IDLE      | line idle, watching for a high->low edge
// S_START     | voting on the start bit; a 1 is treated as a glitch
// S_DATA      | shifting in DATA_BITS votes, LSB first
// S_PARITY    | one parity vote (never entered when PARITY = 0)
// S_STOP      | STOP_BITS votes; the last one completes the frame
module uart_rx_cfg #(
    parameter int CLK_PER_BIT = 100,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    input  logic                 data_ack,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 overrun
);

    // tmr is a down-counter over one bit period: phase = CLK_PER_BIT-1-tmr.
    localparam int            HALF      = CLK_PER_BIT / 2;
    localparam int            TW        = $clog2(CLK_PER_BIT);
    localparam logic [TW-1:0] T_LOAD    = TW'(CLK_PER_BIT - 1);
    localparam logic [TW-1:0] T_FIRST   = TW'(CLK_PER_BIT - 2);
    localparam logic [TW-1:0] T_S0      = TW'(CLK_PER_BIT - HALF);
    localparam logic [TW-1:0] T_S1      = TW'(CLK_PER_BIT - 1 - HALF);
    localparam logic [TW-1:0] T_VOTE    = TW'(CLK_PER_BIT - 2 - HALF);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
    localparam bit            HAS_PAR   = (PARITY != 0);

    typedef enum logic [2:0] {
        S_WAIT_IDLE,
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t state, state_nx;

    logic                 sync1, rxs, rxs_d;
    logic [1:0]           warm;
    logic [TW-1:0]        tmr;
    logic [3:0]           bit_cnt;
    logic                 samp_a, samp_b;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit, stop0, stop_ok;

    logic in_frame, vote_now, vote, edge_det, frame_done;
    logic stop_all, stop_first, par_calc, pe_n, fe_n, brk_n, accept;

    // Synchroniser. warm marks when rxs holds a real pin sample rather than
    // the reset value, so a line held low through reset is not seen as idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
            rxs_d <= 1'b1;
            warm  <= 2'b00;
        end else begin
            sync1 <= rx;
            rxs   <= sync1;
            rxs_d <= rxs;
            warm  <= {warm[0], 1'b1};
        end
    end

    assign edge_det = rxs_d & ~rxs;
    assign in_frame = (state == S_START) || (state == S_DATA) ||
                      (state == S_PARITY) || (state == S_STOP);
    assign vote_now = in_frame && (tmr == T_VOTE);
    assign vote     = (samp_a & samp_b) | (samp_a & rxs) | (samp_b & rxs);

    // Stop-bit summary including the vote being decided this cycle.
    assign stop_all   = ((bit_cnt == 4'd0) ? 1'b1 : stop_ok) & vote;
    assign stop_first = (bit_cnt == 4'd0) ? vote : stop0;

    assign par_calc = (^shreg) ^ par_bit;
    assign pe_n     = (PARITY == 1) ? ~par_calc :
                      (PARITY == 2) ?  par_calc : 1'b0;
    assign fe_n     = ~stop_all;
    assign brk_n    = ~stop_first && (shreg == '0) && !(HAS_PAR && par_bit);
    assign accept   = data_valid && data_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_WAIT_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        frame_done = 1'b0;
        case (state)
            S_WAIT_IDLE: if (warm[1] && rxs) state_nx = S_IDLE;
            S_IDLE:      if (edge_det) state_nx = S_START;
            S_START:     if (vote_now) state_nx = vote ? S_IDLE : S_DATA;
            S_DATA: begin
                if (vote_now && bit_cnt == LAST_DATA)
                    state_nx = HAS_PAR ? S_PARITY : S_STOP;
            end
            S_PARITY:    if (vote_now) state_nx = S_STOP;
            S_STOP: begin
                if (vote_now && bit_cnt == LAST_STOP) begin
                    frame_done = 1'b1;
                    state_nx   = stop_all ? S_IDLE : S_WAIT_IDLE;
                end
            end
            default:     state_nx = S_WAIT_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr     <= '0;
            bit_cnt <= 4'd0;
            samp_a  <= 1'b1;
            samp_b  <= 1'b1;
            shreg   <= '0;
            par_bit <= 1'b0;
            stop0   <= 1'b1;
            stop_ok <= 1'b1;
        end else begin
            // The edge cycle is phase 0 of the start bit.
            if (state == S_IDLE) begin
                tmr     <= T_FIRST;
                bit_cnt <= 4'd0;
            end else if (in_frame) begin
                tmr <= (tmr == '0) ? T_LOAD : tmr - 1'b1;
            end

            if (in_frame && tmr == T_S0) samp_a <= rxs;
            if (in_frame && tmr == T_S1) samp_b <= rxs;

            if (vote_now) begin
                bit_cnt <= (state_nx != state) ? 4'd0 : bit_cnt + 4'd1;
                case (state)
                    S_DATA:   shreg   <= {vote, shreg[DATA_BITS-1:1]};
                    S_PARITY: par_bit <= vote;
                    S_STOP: begin
                        if (bit_cnt == 4'd0) begin
                            stop0   <= vote;
                            stop_ok <= vote;
                        end else begin
                            stop_ok <= stop_ok & vote;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Output holding register. A completion coinciding with an ack replaces
    // the held word rather than counting as an overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data       <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            break_det  <= 1'b0;
            overrun    <= 1'b0;
        end else if (frame_done && (!data_valid || accept)) begin
            data       <= shreg;
            data_valid <= 1'b1;
            parity_err <= pe_n;
            frame_err  <= fe_n;
            break_det  <= fe_n & brk_n;
            overrun    <= 1'b0;
        end else if (frame_done) begin
            overrun <= 1'b1;
        end else if (accept) begin
            data       <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            break_det  <= 1'b0;
            overrun    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Testbench for uart_rx_cfg. Three instances share clk/rst_n:
//   ch0: defaults (8N1, 100 clocks/bit) for timing and scenario tests
//   ch1: 8N1 at 10 clocks/bit for the full byte sweep
//   ch2: 7 data bits, even parity, 2 stop bits, 16 clocks/bit
// Stimulus tasks start and end at posedge+1; outputs are sampled on negedge.
module tb_uart_rx_cfg;

    localparam int CPB0 = 100;
    localparam int CPB1 = 10;
    localparam int CPB2 = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] rx_l;
    logic [2:0] ack_l;
    logic [2:0] dv_l, pe_l, fe_l, bk_l, ov_l;
    logic [7:0] data0, data1;
    logic [6:0] data2;

    int checks = 0;
    int fails  = 0;

    // Scoreboard entries: {break, frame_err, parity_err, data[8:0]}
    logic [11:0] exp_q[$];

    always #5 clk = ~clk;

    uart_rx_cfg u_ch0 (
        .clk(clk), .rst_n(rst_n), .rx(rx_l[0]), .data(data0),
        .data_valid(dv_l[0]), .data_ack(ack_l[0]), .parity_err(pe_l[0]),
        .frame_err(fe_l[0]), .break_det(bk_l[0]), .overrun(ov_l[0])
    );

    uart_rx_cfg #(.CLK_PER_BIT(CPB1)) u_ch1 (
        .clk(clk), .rst_n(rst_n), .rx(rx_l[1]), .data(data1),
        .data_valid(dv_l[1]), .data_ack(ack_l[1]), .parity_err(pe_l[1]),
        .frame_err(fe_l[1]), .break_det(bk_l[1]), .overrun(ov_l[1])
    );

    uart_rx_cfg #(.CLK_PER_BIT(CPB2), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_ch2 (
        .clk(clk), .rst_n(rst_n), .rx(rx_l[2]), .data(data2),
        .data_valid(dv_l[2]), .data_ack(ack_l[2]), .parity_err(pe_l[2]),
        .frame_err(fe_l[2]), .break_det(bk_l[2]), .overrun(ov_l[2])
    );

    function automatic logic [11:0] obs(input logic [1:0] ch);
        case (ch)
            2'd0:    return {bk_l[0], fe_l[0], pe_l[0], 1'b0, data0};
            2'd1:    return {bk_l[1], fe_l[1], pe_l[1], 1'b0, data1};
            default: return {bk_l[2], fe_l[2], pe_l[2], 2'b00, data2};
        endcase
    endfunction

    // Serialises one frame; par: 0 none, 1 odd, 2 even; flip inverts parity.
    task automatic tx_frame(input logic [1:0] ch, input int cpb, input int nb,
                            input logic [8:0] w, input int par, input int nstop,
                            input bit flip);
        logic [15:0] bits;
        logic        p;
        int          n;
        bits    = '1;
        bits[0] = 1'b0;
        p       = 1'b0;
        for (int i = 0; i < nb; i++) begin
            bits[1+i] = w[i];
            p         = p ^ w[i];
        end
        n = 1 + nb;
        if (par != 0) begin
            if (par == 1) p = ~p;
            if (flip)     p = ~p;
            bits[n] = p;
            n       = n + 1;
        end
        n = n + nstop;
        for (int i = 0; i < n; i++) begin
            rx_l[ch] = bits[i];
            repeat (cpb) @(posedge clk);
            #1;
        end
        rx_l[ch] = 1'b1;
    endtask

    // Counts posedges until data_valid is seen high; cyc = -1 on timeout.
    task automatic wait_word(input logic [1:0] ch, input int limit, output int cyc);
        bit found;
        found = 1'b0;
        cyc   = 0;
        while (!found && cyc < limit) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (dv_l[ch]) found = 1'b1;
        end
        if (!found) cyc = -1;
    endtask

    task automatic pulse_ack(input logic [1:0] ch);
        @(posedge clk); #1;
        ack_l[ch] = 1'b1;
        @(posedge clk); #1;
        ack_l[ch] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx_l  = 3'b111;
        ack_l = 3'b000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({dv_l, pe_l, fe_l, bk_l, ov_l} !== 15'd0) begin
            fails++;
            $display("FAIL reset_flags: got %b, want 0", {dv_l, pe_l, fe_l, bk_l, ov_l});
        end
        checks++;
        if ({data0, data1, data2} !== 23'd0) begin
            fails++;
            $display("FAIL reset_data: got %h/%h/%h, want 0", data0, data1, data2);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks++;
        if (dv_l !== 3'b000) begin
            fails++;
            $display("FAIL reset_release_valid: got %b, want 000", dv_l);
        end
        @(posedge clk); #1;
    endtask

    // ch0 a few bytes at 100 clocks/bit, then ch1 all 256 byte values.
    task automatic test_loopback();
        int          cyc, cpb, lat;
        logic [1:0]  ch;
        logic [7:0]  b;
        logic [7:0]  sel [4];
        logic [11:0] e, got;
        sel[0] = 8'h00; sel[1] = 8'hFF; sel[2] = 8'hA5; sel[3] = 8'h3C;
        for (int k = 0; k < 260; k++) begin
            if (k < 4) begin
                ch = 2'd0; cpb = CPB0; b = sel[k];
            end else begin
                ch = 2'd1; cpb = CPB1; b = 8'(k - 4);
            end
            // 2 synchroniser cycles, then last stop centre + vote + register
            lat = 2 + 9 * cpb + cpb / 2 + 2;
            exp_q.push_back({3'b000, 1'b0, b});
            fork
                tx_frame(ch, cpb, 8, {1'b0, b}, 0, 1, 1'b0);
                begin
                    wait_word(ch, lat + 20, cyc);
                    e = exp_q.pop_front();
                    checks++;
                    if (cyc < 0) begin
                        fails++;
                        $display("FAIL loopback_timeout ch%0d byte %h: no data_valid in %0d cycles", ch, b, lat + 20);
                    end else begin
                        got = obs(ch);
                        if (got !== e) begin
                            fails++;
                            $display("FAIL loopback_word ch%0d: got %h, want %h", ch, got, e);
                        end
                        checks++;
                        if (cyc != lat) begin
                            fails++;
                            $display("FAIL loopback_latency ch%0d byte %h: got %0d, want %0d", ch, b, cyc, lat);
                        end
                        checks++;
                        if (ov_l[ch] !== 1'b0) begin
                            fails++;
                            $display("FAIL loopback_overrun ch%0d: got %b, want 0", ch, ov_l[ch]);
                        end
                        pulse_ack(ch);
                    end
                end
            join
        end
    endtask

    task automatic test_parity();
        int          cyc, lat;
        logic [11:0] e, got;
        lat = 2 + 10 * CPB2 + CPB2 / 2 + 2;
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back({2'b00, (k == 1), 2'b00, 7'h55});
            fork
                tx_frame(2'd2, CPB2, 7, 9'h055, 2, 2, (k == 1));
                begin
                    wait_word(2'd2, lat + 20, cyc);
                    e = exp_q.pop_front();
                    checks++;
                    if (cyc < 0) begin
                        fails++;
                        $display("FAIL parity_timeout frame %0d", k);
                    end else begin
                        got = obs(2'd2);
                        if (got !== e) begin
                            fails++;
                            $display("FAIL parity_word frame %0d: got %h, want %h", k, got, e);
                        end
                        checks++;
                        if (cyc != lat) begin
                            fails++;
                            $display("FAIL parity_latency frame %0d: got %0d, want %0d", k, cyc, lat);
                        end
                        pulse_ack(2'd2);
                    end
                end
            join
        end
    endtask

    task automatic test_glitch();
        int          cyc;
        bit          saw;
        logic [11:0] e, got;
        rx_l[0] = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rx_l[0] = 1'b1;
        saw = 1'b0;
        repeat (400) begin
            @(negedge clk);
            if (dv_l[0]) saw = 1'b1;
            @(posedge clk);
        end
        #1;
        checks++;
        if (saw) begin
            fails++;
            $display("FAIL glitch_no_word: got data_valid, want none");
        end
        exp_q.push_back({3'b000, 9'h0A3});
        fork
            tx_frame(2'd0, CPB0, 8, 9'h0A3, 0, 1, 1'b0);
            begin
                wait_word(2'd0, 1000, cyc);
                e = exp_q.pop_front();
                got = obs(2'd0);
                checks++;
                if (cyc < 0 || got !== e) begin
                    fails++;
                    $display("FAIL glitch_frame: got %h (cyc %0d), want %h", got, cyc, e);
                end
                pulse_ack(2'd0);
            end
        join
    endtask

    task automatic test_break();
        int          cyc;
        bit          saw;
        logic [11:0] e, got;
        exp_q.push_back({1'b1, 1'b1, 1'b0, 9'h000});
        fork
            begin
                rx_l[0] = 1'b0;
                repeat (15 * CPB0) @(posedge clk);
                #1;
                rx_l[0] = 1'b1;
            end
            begin
                wait_word(2'd0, 1200, cyc);
                e = exp_q.pop_front();
                got = obs(2'd0);
                checks++;
                if (got !== e) begin
                    fails++;
                    $display("FAIL break_word: got %h, want %h", got, e);
                end
                checks++;
                if (cyc != 954) begin
                    fails++;
                    $display("FAIL break_latency: got %0d, want 954", cyc);
                end
                pulse_ack(2'd0);
            end
        join
        saw = 1'b0;
        repeat (1000) begin
            @(negedge clk);
            if (dv_l[0]) saw = 1'b1;
            @(posedge clk);
        end
        #1;
        checks++;
        if (saw) begin
            fails++;
            $display("FAIL break_single_word: got extra data_valid, want none");
        end
        exp_q.push_back({3'b000, 9'h07E});
        fork
            tx_frame(2'd0, CPB0, 8, 9'h07E, 0, 1, 1'b0);
            begin
                wait_word(2'd0, 1000, cyc);
                e = exp_q.pop_front();
                got = obs(2'd0);
                checks++;
                if (cyc < 0 || got !== e) begin
                    fails++;
                    $display("FAIL break_recover: got %h (cyc %0d), want %h", got, cyc, e);
                end
                pulse_ack(2'd0);
            end
        join
    endtask

    task automatic test_back_to_back();
        int          cyc;
        bit          saw;
        logic [11:0] e, got;
        exp_q.push_back({3'b000, 9'h011});
        fork
            begin
                tx_frame(2'd0, CPB0, 8, 9'h011, 0, 1, 1'b0);
                tx_frame(2'd0, CPB0, 8, 9'h022, 0, 1, 1'b0);
            end
            begin
                wait_word(2'd0, 1000, cyc);
                e = exp_q.pop_front();
                got = obs(2'd0);
                checks++;
                if (cyc < 0 || got !== e) begin
                    fails++;
                    $display("FAIL b2b_first: got %h (cyc %0d), want %h", got, cyc, e);
                end
            end
        join
        @(negedge clk);
        checks++;
        if ({dv_l[0], ov_l[0], data0} !== {1'b1, 1'b1, 8'h11}) begin
            fails++;
            $display("FAIL overrun_hold: got dv=%b ov=%b data=%h, want dv=1 ov=1 data=11", dv_l[0], ov_l[0], data0);
        end
        @(posedge clk); #1;
        pulse_ack(2'd0);
        @(negedge clk);
        checks++;
        if ({dv_l[0], ov_l[0], obs(2'd0)} !== 14'd0) begin
            fails++;
            $display("FAIL overrun_ack_clear: got dv=%b ov=%b word=%h, want all 0", dv_l[0], ov_l[0], obs(2'd0));
        end
        saw = 1'b0;
        repeat (500) begin
            @(negedge clk);
            if (dv_l[0]) saw = 1'b1;
            @(posedge clk);
        end
        #1;
        checks++;
        if (saw) begin
            fails++;
            $display("FAIL overrun_dropped: dropped word was delivered");
        end

        // Ack during the completion cycle with nothing held: ignored.
        exp_q.push_back({3'b000, 9'h033});
        fork
            tx_frame(2'd0, CPB0, 8, 9'h033, 0, 1, 1'b0);
            begin
                repeat (953) @(posedge clk);
                #1; ack_l[0] = 1'b1;
                @(posedge clk);
                #1; ack_l[0] = 1'b0;
            end
            begin
                wait_word(2'd0, 1000, cyc);
                e = exp_q.pop_front();
                got = obs(2'd0);
                checks++;
                if (cyc != 954 || got !== e || ov_l[0] !== 1'b0) begin
                    fails++;
                    $display("FAIL ack_idle_completion: got %h ov=%b cyc=%0d, want %h ov=0 cyc=954", got, ov_l[0], cyc, e);
                end
            end
        join

        // Ack in the completion cycle while 0x33 is held: 0x44 replaces it.
        exp_q.push_back({3'b000, 9'h044});
        fork
            tx_frame(2'd0, CPB0, 8, 9'h044, 0, 1, 1'b0);
            begin
                repeat (953) @(posedge clk);
                #1; ack_l[0] = 1'b1;
                @(negedge clk);
                checks++;
                if ({dv_l[0], data0} !== {1'b1, 8'h33}) begin
                    fails++;
                    $display("FAIL simul_before: got dv=%b data=%h, want dv=1 data=33", dv_l[0], data0);
                end
                @(posedge clk);
                #1; ack_l[0] = 1'b0;
                @(negedge clk);
                e = exp_q.pop_front();
                got = obs(2'd0);
                checks++;
                if ({dv_l[0], ov_l[0], got} !== {1'b1, 1'b0, e}) begin
                    fails++;
                    $display("FAIL simul_load: got dv=%b ov=%b word=%h, want dv=1 ov=0 word=%h", dv_l[0], ov_l[0], got, e);
                end
            end
        join
        pulse_ack(2'd0);
        @(negedge clk);
        checks++;
        if (dv_l[0] !== 1'b0) begin
            fails++;
            $display("FAIL simul_final_ack: got dv=%b, want 0", dv_l[0]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midframe();
        int          cyc;
        bit          saw;
        logic [11:0] e, got;
        saw = 1'b0;
        fork
            tx_frame(2'd0, CPB0, 8, 9'h0F0, 0, 1, 1'b0);
            begin
                repeat (250) @(posedge clk);
                #1; rst_n = 1'b0;
                repeat (5) @(posedge clk);
                #1; rst_n = 1'b1;
            end
            begin
                repeat (1100) begin
                    @(negedge clk);
                    if (dv_l[0]) saw = 1'b1;
                    @(posedge clk);
                end
                #1;
            end
        join
        checks++;
        if (saw) begin
            fails++;
            $display("FAIL midreset_discard: interrupted frame produced data_valid");
        end
        exp_q.push_back({3'b000, 9'h05A});
        fork
            tx_frame(2'd0, CPB0, 8, 9'h05A, 0, 1, 1'b0);
            begin
                wait_word(2'd0, 1000, cyc);
                e = exp_q.pop_front();
                got = obs(2'd0);
                checks++;
                if (cyc != 954 || got !== e) begin
                    fails++;
                    $display("FAIL midreset_next: got %h cyc=%0d, want %h cyc=954", got, cyc, e);
                end
                pulse_ack(2'd0);
            end
        join
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_parity();
        test_glitch();
        test_break();
        test_back_to_back();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
